// File: rtl/fifo_rr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among n_req producers.
// Grants last up to `burst` words; every word carries its producer index.
module fifo_rr_arbiter #(
  parameter  int width = 16,
  parameter  int n_req = 4,
  parameter  int burst = 8,
  localparam int TW    = $clog2(n_req),
  localparam int CW    = $clog2(burst) + 1
) (
  input  logic                   clk,
  input  logic                   ap_rst,
  input  logic [n_req*width-1:0] req_din,
  input  logic [n_req-1:0]       req_write,
  output logic [n_req-1:0]       req_full_n,
  output logic [width-1:0]       fifo_din,
  output logic                   fifo_write,
  input  logic                   fifo_full_n,
  output logic [TW-1:0]          fifo_tag,
  output logic                   grant_valid,
  output logic [TW-1:0]          grant_id
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q;
  logic [TW-1:0]  grant_q;
  logic [TW-1:0]  ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           grant_valid_q;

  logic [width-1:0] din_arr [n_req];
  logic [TW-1:0]    pick_idx;
  logic [TW-1:0]    cand_idx;
  logic             pick_found;
  logic [TW-1:0]    ptr_after;
  logic             in_grant;
  logic             cur_write;
  int               scan_idx;

  // First requester at or after ptr_q, wrapping modulo n_req.
  // NOTE: every combinational output gets a default before any conditional
  // assignment so no latch is inferred.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = 0;
    for (int i = 0; i < n_req; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= n_req) scan_idx = scan_idx - n_req;
      cand_idx = TW'(scan_idx);
      if (!pick_found && req_write[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < n_req; i++) din_arr[i] = req_din[i*width +: width];
  end

  assign ptr_after = (grant_q == TW'(n_req - 1)) ? '0 : grant_q + TW'(1);
  assign in_grant  = (state_q == GRANT);
  assign cur_write = req_write[grant_q];

  // The FIFO RAM writes without looking at full, so the strobe is gated here.
  always_comb begin
    req_full_n = '0;
    if (in_grant) req_full_n[grant_q] = fifo_full_n;
    fifo_write  = in_grant && cur_write && fifo_full_n;
    fifo_din    = din_arr[grant_q];
    fifo_tag    = grant_q;
    grant_valid = grant_valid_q;
    grant_id    = grant_q;
  end

  // NOTE: state registers use non-blocking assignments and reset
  // asynchronously, so a reset mid-burst drops fifo_write in the same cycle.
  always_ff @(posedge clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q       <= pick_idx;
            cnt_q         <= '0;
            state_q       <= GRANT;
            grant_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (fifo_write) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(burst - 1)) begin
              state_q       <= IDLE;
              grant_valid_q <= 1'b0;
              ptr_q         <= ptr_after;
            end
          end else if (!cur_write) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            ptr_q         <= ptr_after;
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench: two arbiters (4 req / burst 8 and 3 req / burst 1) fed by
// queue-backed producers; a negedge monitor pops expected {tag,data} per write.
module tb_fifo_rr_arbiter;
  localparam int W = 16;

  typedef struct packed {
    logic [1:0]   tag;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic ap_rst;
  always #5 clk = ~clk;

  // DUT A: n_req=4, burst=8
  logic [4*W-1:0] a_din;
  logic [3:0]     a_wr, a_fn;
  logic [W-1:0]   a_fdin;
  logic           a_fwr, a_ffn, a_gv;
  logic [1:0]     a_tag, a_gid;

  // DUT B: n_req=3, burst=1
  logic [3*W-1:0] b_din;
  logic [2:0]     b_wr, b_fn;
  logic [W-1:0]   b_fdin;
  logic           b_fwr, b_ffn, b_gv;
  logic [1:0]     b_tag, b_gid;

  fifo_rr_arbiter #(.width(W), .n_req(4), .burst(8)) dut_a (
    .clk(clk), .ap_rst(ap_rst), .req_din(a_din), .req_write(a_wr),
    .req_full_n(a_fn), .fifo_din(a_fdin), .fifo_write(a_fwr),
    .fifo_full_n(a_ffn), .fifo_tag(a_tag), .grant_valid(a_gv), .grant_id(a_gid)
  );

  fifo_rr_arbiter #(.width(W), .n_req(3), .burst(1)) dut_b (
    .clk(clk), .ap_rst(ap_rst), .req_din(b_din), .req_write(b_wr),
    .req_full_n(b_fn), .fifo_din(b_fdin), .fifo_write(b_fwr),
    .fifo_full_n(b_ffn), .fifo_tag(b_tag), .grant_valid(b_gv), .grant_id(b_gid)
  );

  logic [W-1:0] qa [4][$];
  logic [W-1:0] qb [3][$];
  int           sent_a [4];
  exp_t         exp_a [$];
  exp_t         exp_b [$];
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic refresh_a();
    for (int i = 0; i < 4; i++) begin
      a_wr[i]          = (qa[i].size() != 0);
      a_din[i*W +: W]  = (qa[i].size() != 0) ? qa[i][0] : '0;
    end
  endtask

  task automatic refresh_b();
    for (int i = 0; i < 3; i++) begin
      b_wr[i]          = (qb[i].size() != 0);
      b_din[i*W +: W]  = (qb[i].size() != 0) ? qb[i][0] : '0;
    end
  endtask

  task automatic push_a(input int i, input logic [W-1:0] base, input int n);
    for (int k = 0; k < n; k++) qa[i].push_back(base + W'(k));
  endtask

  task automatic exp_push_a(input logic [1:0] tag, input logic [W-1:0] base, input int n);
    for (int k = 0; k < n; k++) exp_a.push_back('{tag: tag, data: base + W'(k)});
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    @(posedge clk); #2;
    ap_rst = 1'b0;
  endtask

  // Counts negedges from the call until every expected A word has been seen.
  task automatic drain_a(input string name, input int budget, output int cyc);
    cyc = 0;
    while (exp_a.size() != 0 && cyc < budget) begin
      @(negedge clk); #1;
      cyc++;
    end
    check({name, "_drained"}, exp_a.size(), 0);
  endtask

  task automatic wait_sent_a(input int i, input int n, input int budget);
    int c = 0;
    while (sent_a[i] < n && c < budget) begin
      @(posedge clk); #2;
      c++;
    end
    check($sformatf("sent_a%0d_reached_%0d", i, n), sent_a[i], n);
  endtask

  // Producers: a word leaves its queue on an edge where write && full_n held.
  initial begin : drv_a
    logic [3:0] acc;
    forever begin
      @(negedge clk);
      acc = a_wr & a_fn;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (acc[i] && !ap_rst && qa[i].size() != 0) begin
          void'(qa[i].pop_front());
          sent_a[i]++;
        end
      refresh_a();
    end
  end

  initial begin : drv_b
    logic [2:0] acc;
    forever begin
      @(negedge clk);
      acc = b_wr & b_fn;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (acc[i] && !ap_rst && qb[i].size() != 0) void'(qb[i].pop_front());
      refresh_b();
    end
  end

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_fwr) begin
      if (exp_a.size() == 0) check("a_unexpected_write", {a_tag, a_fdin}, 32'hFFFF_FFFF);
      else begin
        e = exp_a.pop_front();
        check("a_word_tag_data", {a_tag, a_fdin}, {e.tag, e.data});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_fwr) begin
      check("b_tag_below_3", (b_tag < 2'd3), 1);
      if (exp_b.size() == 0) check("b_unexpected_write", {b_tag, b_fdin}, 32'hFFFF_FFFF);
      else begin
        e = exp_b.pop_front();
        check("b_word_tag_data", {b_tag, b_fdin}, {e.tag, e.data});
      end
    end
  end

  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) sent_a[i] = 0;
    ap_rst = 1'b1;
    a_ffn  = 1'b1;
    b_ffn  = 1'b1;
    refresh_a();
    refresh_b();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_full_n", a_fn, 0);
    check("rst_a_write", a_fwr, 0);
    check("rst_a_grant", {a_gv, a_gid, a_tag}, 0);
    check("rst_b_outs", {b_fn, b_fwr, b_gv, b_gid, b_tag}, 0);
    @(posedge clk); #2;
    ap_rst = 1'b0;

    // 1: single requester 2, one bubble then 8 back-to-back words.
    @(posedge clk); #2;
    push_a(2, 16'h0010, 8);
    exp_push_a(2, 16'h0010, 8);
    refresh_a();
    #1;
    check("t1_idle_no_accept", a_fn, 0);
    check("t1_idle_grant_valid", a_gv, 0);
    drain_a("t1", 40, cyc);
    check("t1_cycles_incl_bubble", cyc, 9);
    @(posedge clk); #2;
    check("t1_back_to_idle", a_gv, 0);
    check("t1_sent", sent_a[2], 8);
    // ptr is now 3: requester 3 must win over requester 1.
    push_a(1, 16'h0021, 1);
    push_a(3, 16'h0031, 1);
    exp_push_a(3, 16'h0031, 1);
    exp_push_a(1, 16'h0021, 1);
    refresh_a();
    drain_a("t1_ptr", 20, cyc);
    @(posedge clk); #2;

    // 2: all four saturated; grants 0,1,2,3,0, burst/(burst+1) throughput.
    do_reset();
    push_a(0, 16'h0100, 16);
    push_a(1, 16'h0200, 8);
    push_a(2, 16'h0300, 8);
    push_a(3, 16'h0400, 8);
    exp_push_a(0, 16'h0100, 8);
    exp_push_a(1, 16'h0200, 8);
    exp_push_a(2, 16'h0300, 8);
    exp_push_a(3, 16'h0400, 8);
    exp_push_a(0, 16'h0108, 8);
    refresh_a();
    drain_a("t2", 200, cyc);
    check("t2_cycles_5_grants", cyc, 45);
    @(posedge clk); #2;

    // 3: stall for 5 cycles after requester 1's third word.
    do_reset();
    for (int i = 0; i < 4; i++) sent_a[i] = 0;
    push_a(1, 16'h0500, 8);
    exp_push_a(1, 16'h0500, 8);
    refresh_a();
    wait_sent_a(1, 3, 20);
    a_ffn = 1'b0;
    #1;
    check("t3_stall_no_write", a_fwr, 0);
    check("t3_stall_full_n", a_fn, 0);
    check("t3_stall_grant_held", {a_gv, a_gid}, {1'b1, 2'd1});
    repeat (5) @(posedge clk);
    #1;
    check("t3_stall_sent_held", sent_a[1], 3);
    check("t3_stall_still_granted", {a_gv, a_gid}, {1'b1, 2'd1});
    #1;
    a_ffn = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("t3_resume_sent", sent_a[1], 8);
    check("t3_resume_back_idle", a_gv, 0);
    drain_a("t3", 10, cyc);
    @(posedge clk); #2;

    // 4: requester 0 drops after 3 words; 3 is served before 0 returns.
    do_reset();
    for (int i = 0; i < 4; i++) sent_a[i] = 0;
    push_a(0, 16'h0600, 3);
    push_a(3, 16'h0700, 2);
    exp_push_a(0, 16'h0600, 3);
    exp_push_a(3, 16'h0700, 2);
    refresh_a();
    wait_sent_a(0, 3, 20);
    @(posedge clk); #2;
    check("t4_release_idle", a_gv, 0);
    push_a(0, 16'h0610, 2);
    exp_push_a(0, 16'h0610, 2);
    refresh_a();
    @(posedge clk); #2;
    check("t4_next_grant_is_3", {a_gv, a_gid}, {1'b1, 2'd3});
    drain_a("t4", 30, cyc);
    @(posedge clk); #2;

    // 5: reset mid-burst; arbitration restarts from index 0.
    do_reset();
    for (int i = 0; i < 4; i++) sent_a[i] = 0;
    push_a(1, 16'h0800, 8);
    exp_push_a(1, 16'h0800, 8);
    refresh_a();
    drain_a("t5_pre", 40, cyc);
    @(posedge clk); #2;
    push_a(2, 16'h0900, 8);
    exp_push_a(2, 16'h0900, 4);
    refresh_a();
    wait_sent_a(2, 4, 20);
    ap_rst = 1'b1;
    #1;
    check("t5_rst_write", a_fwr, 0);
    check("t5_rst_full_n", a_fn, 0);
    check("t5_rst_grant", {a_gv, a_gid, a_tag}, 0);
    push_a(0, 16'h0A00, 2);
    exp_push_a(0, 16'h0A00, 2);
    exp_push_a(2, 16'h0904, 4);
    refresh_a();
    @(posedge clk); #2;
    check("t5_rst_cycle_sent", sent_a[2], 4);
    ap_rst = 1'b0;
    drain_a("t5_post", 40, cyc);
    @(posedge clk); #2;

    // 6: n_req=3, burst=1, all requesting; one word per grant, 0,1,2,0,1,2.
    do_reset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2; k++) qb[i].push_back(16'h0B00 + W'(i*16 + k));
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++)
        exp_b.push_back('{tag: 2'(i), data: 16'h0B00 + W'(i*16 + k)});
    refresh_b();
    cyc = 0;
    while (exp_b.size() != 0 && cyc < 60) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("t6_drained", exp_b.size(), 0);
    check("t6_cycles_one_word_per_grant", cyc, 12);
    @(posedge clk); #2;
    check("t6_back_idle", b_gv, 0);

    check("queues_a_empty", qa[0].size() + qa[1].size() + qa[2].size() + qa[3].size(), 0);
    check("queues_b_empty", qb[0].size() + qb[1].size() + qb[2].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
